// File: rtl/lotr_pkg.sv
// Shared LOTR ring types: packet struct, opcodes, broadcast ID and target-ID legality check.
// No logic of its own. Latency and backpressure do not apply.
// Imported by the ring loopback stage, its channel sub-module and the channel interface.
package lotr_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_RD     = 4'h1,
      OP_WR     = 4'h2,
      OP_RD_RSP = 4'h3,
      OP_WR_RSP = 4'h4
   } t_opcode;

   typedef struct packed {
      logic        valid;
      logic [9:0]  requestor;
      t_opcode     opcode;
      logic [31:0] address;     // [31:24] = target ID
      logic [31:0] data;
   } t_ring_pkt;

   localparam logic [7:0] RING_BCAST_ID = 8'hFF;

   // A target ID is legal when it names a ring tile (1..num_tile) or is broadcast.
   // ID 0 is never a tile.
   function automatic logic ring_id_legal(input logic [7:0]  id,
                                          input int unsigned num_tile,
                                          input logic [7:0]  bcast_id = RING_BCAST_ID);
      int unsigned id_u;
      id_u = {24'd0, id};
      return ((id_u != 0) && (id_u <= num_tile)) || (id == bcast_id);
   endfunction

endpackage

// File: rtl/ring_loopback_stage_if.sv
// One ring channel (Req or Rsp) as a bundle of the five packet fields.
// No latency of its own. There is no backpressure: a valid beat is taken every cycle.
// The master drives the packet and the slave receives it.
interface ring_loopback_stage_if;
   import lotr_pkg::*;

   t_ring_pkt pkt;

   modport master (output pkt);
   modport slave  (input  pkt);
endinterface

// File: rtl/ring_gc_channel.sv
// One ring channel: target-ID legality check, output register and saturating drop counter.
// Latency is 1 cycle, input to registered output. There is no backpressure: a beat is taken every cycle.
// Ports: in_pkt/out_pkt carry the packet. drop is a combinational drop pulse. drop_clr clears the counter.
module ring_gc_channel
   import lotr_pkg::*;
#(
   parameter int unsigned NUM_TILE = 4,
   parameter logic [7:0]  BCAST_ID = RING_BCAST_ID,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             QClk,
   input  logic             RstQnnnL,
   input  t_ring_pkt        in_pkt,
   input  logic             drop_clr,
   output t_ring_pkt        out_pkt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             drop
);

   logic legal;

   assign legal = ring_id_legal(in_pkt.address[31:24], NUM_TILE, BCAST_ID);
   // Invalid beats carry garbage addresses, so they never count as drops.
   assign drop  = in_pkt.valid && !legal;

   // A killed packet still loads the payload so its fields are visible for debug.
   // Only valid is forced low.
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         out_pkt <= '0;
      end else begin
         out_pkt.valid <= in_pkt.valid && legal;
         if (in_pkt.valid) begin
            out_pkt.requestor <= in_pkt.requestor;
            out_pkt.opcode    <= in_pkt.opcode;
            out_pkt.address   <= in_pkt.address;
            out_pkt.data      <= in_pkt.data;
         end
      end
   end

   // A clear that coincides with a drop leaves the count at 1.
   // The count saturates and never wraps.
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         drop_cnt <= '0;
      end else if (drop_clr) begin
         drop_cnt <= drop ? CNT_W'(1) : '0;
      end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
         drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ring_loopback_stage.sv
// Closing stage of the LOTR ring. It registers Req/Rsp from the last tile into tile 1 and kills packets with illegal target IDs.
// Latency is 1 cycle per channel. There is no backpressure: each channel takes one packet every cycle.
// Ports: QClk/RstQnnnL, the channel bundles, DropClr, per-channel drop counts and the first-drop capture.
module ring_loopback_stage
   import lotr_pkg::*;
#(
   parameter int unsigned NUM_TILE = 4,
   parameter logic [7:0]  BCAST_ID = RING_BCAST_ID,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                  QClk,
   input  logic                  RstQnnnL,
   ring_loopback_stage_if.slave  ReqInQ502H,
   ring_loopback_stage_if.slave  RspInQ502H,
   ring_loopback_stage_if.master ReqOutQ500H,
   ring_loopback_stage_if.master RspOutQ500H,
   input  logic                  DropClr,
   output logic [CNT_W-1:0]      ReqDropCnt,
   output logic [CNT_W-1:0]      RspDropCnt,
   output logic                  DropCapValid,
   output logic                  DropCapIsRsp,
   output logic [9:0]            DropCapRequestor,
   output logic [31:0]           DropCapAddress
);

   t_ring_pkt req_out_q;
   t_ring_pkt rsp_out_q;
   logic      req_drop;
   logic      rsp_drop;
   logic      cap_free;

   ring_gc_channel #(.NUM_TILE(NUM_TILE), .BCAST_ID(BCAST_ID), .CNT_W(CNT_W)) u_req (
      .QClk     (QClk),
      .RstQnnnL (RstQnnnL),
      .in_pkt   (ReqInQ502H.pkt),
      .drop_clr (DropClr),
      .out_pkt  (req_out_q),
      .drop_cnt (ReqDropCnt),
      .drop     (req_drop)
   );

   ring_gc_channel #(.NUM_TILE(NUM_TILE), .BCAST_ID(BCAST_ID), .CNT_W(CNT_W)) u_rsp (
      .QClk     (QClk),
      .RstQnnnL (RstQnnnL),
      .in_pkt   (RspInQ502H.pkt),
      .drop_clr (DropClr),
      .out_pkt  (rsp_out_q),
      .drop_cnt (RspDropCnt),
      .drop     (rsp_drop)
   );

   assign ReqOutQ500H.pkt = req_out_q;
   assign RspOutQ500H.pkt = rsp_out_q;

   // A clear in the same cycle frees the capture, so a coincident drop is captured at once.
   assign cap_free = !DropCapValid || DropClr;

   // The capture holds the first drop. Req wins when both channels drop together.
   // A clear with no drop only lowers DropCapValid. The stale fields are left in place.
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         DropCapValid     <= 1'b0;
         DropCapIsRsp     <= 1'b0;
         DropCapRequestor <= '0;
         DropCapAddress   <= '0;
      end else if (cap_free && req_drop) begin
         DropCapValid     <= 1'b1;
         DropCapIsRsp     <= 1'b0;
         DropCapRequestor <= ReqInQ502H.pkt.requestor;
         DropCapAddress   <= ReqInQ502H.pkt.address;
      end else if (cap_free && rsp_drop) begin
         DropCapValid     <= 1'b1;
         DropCapIsRsp     <= 1'b1;
         DropCapRequestor <= RspInQ502H.pkt.requestor;
         DropCapAddress   <= RspInQ502H.pkt.address;
      end else if (DropClr) begin
         DropCapValid     <= 1'b0;
      end
   end

endmodule
